// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues EX/MEM loads/stores to the data cache, stalls until dhit, loads MEM/WB.
// Optional load-linked/store-conditional support is compiled in when LLSC_EN is defined.
//
// state | meaning
// IDLE  | no access outstanding; a hit completes here with zero stall
// WAIT  | request held on the cache, waiting for dhit
// ERR   | WAIT_LIMIT exceeded; requests off, stall held until reset
module mem_stage_ctrl #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren_EX_MEM,
  input  logic        wen_EX_MEM,
  input  logic [31:0] dmemaddr_EX_MEM,
  input  logic [31:0] dmemstore_EX_MEM,
  input  logic [31:0] result_EX_MEM,
  input  logic        WEN_EX_MEM,
  input  logic [4:0]  wsel_EX_MEM,
  input  logic        flush_MEM_WB,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        mem_timeout,
  output logic [31:0] wdat_MEM_WB,
  output logic [4:0]  wsel_MEM_WB,
  output logic        WEN_MEM_WB
`ifdef LLSC_EN
  ,
  input  logic        ll_EX_MEM,
  input  logic        sc_EX_MEM
`endif
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [4:0]    wsel_q, wsel_d;
  logic          wen_wb_q, wen_wb_d;

  logic rd, wr, req, active;

`ifdef LLSC_EN
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        sc_ok;

  assign sc_ok = link_valid_q & (dmemaddr_EX_MEM == link_addr_q);
  assign rd    = ren_EX_MEM | ll_EX_MEM;
  // A failing SC never reaches the cache, so it raises no request and no stall.
  assign wr    = ~rd & ((wen_EX_MEM & ~sc_EX_MEM) | (sc_EX_MEM & sc_ok));
`else
  assign rd = ren_EX_MEM;
  assign wr = ~ren_EX_MEM & wen_EX_MEM;
`endif

  assign req = rd | wr;
  // Gating with nRST drops the request the moment reset asserts mid-access.
  assign active = req & (state_q != ERR) & nRST;

  assign dmemREN     = active & rd;
  assign dmemWEN     = active & wr;
  assign dmemaddr    = active ? dmemaddr_EX_MEM : 32'h0;
  assign dmemstore   = active ? dmemstore_EX_MEM : 32'h0;
  assign mem_stall   = (active & ~dhit) | (state_q == ERR);
  assign mem_timeout = (state_q == ERR);

  assign wdat_MEM_WB = wdat_q;
  assign wsel_MEM_WB = wsel_q;
  assign WEN_MEM_WB  = wen_wb_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req && !dhit) state_d = WAIT;
      end
      WAIT: begin
        if (dhit || !req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
          if ((WAIT_LIMIT != 0) && (cnt_d == LIMIT)) state_d = ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wdat_d   = 32'h0;
    wsel_d   = 5'd0;
    wen_wb_d = 1'b0;
    if (!(mem_stall || flush_MEM_WB)) begin
      wsel_d   = wsel_EX_MEM;
      wen_wb_d = WEN_EX_MEM;
      wdat_d   = rd ? dmemload : result_EX_MEM;
`ifdef LLSC_EN
      if (!rd && sc_EX_MEM) wdat_d = {31'b0, sc_ok};
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdat_q   <= 32'h0;
      wsel_q   <= 5'd0;
      wen_wb_q <= 1'b0;
    end else begin
      wdat_q   <= wdat_d;
      wsel_q   <= wsel_d;
      wen_wb_q <= wen_wb_d;
    end
  end

`ifdef LLSC_EN
  logic done;
  assign done = active & dhit;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (done && ll_EX_MEM) begin
      link_valid_d = 1'b1;
      link_addr_d  = dmemaddr_EX_MEM;
    end else if (done && wr && sc_EX_MEM) begin
      link_valid_d = 1'b0;
    end else if (done && wr && (dmemaddr_EX_MEM == link_addr_q)) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'h0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`endif

endmodule
